// File: rtl/diff_commit_sched.sv
// Difftest commit scheduler: buffers up to two commits per cycle and drains them one per cycle,
// emitting exception/mret events only after all older commits. Optional macro: DIFF_SCHED_STALL_CNT_EN.
module diff_commit_sched #(
    parameter int DEPTH = 8,
    parameter int REC_W = 170
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [1:0]       in_valid,
    input  logic [REC_W-1:0] in_rec0,
    input  logic [REC_W-1:0] in_rec1,
    output logic             in_ready,
    input  logic             excp_req,
    input  logic             excp_is_mret,
    input  logic [31:0]      excp_cause,
    input  logic [63:0]      excp_pc,
    output logic             excp_ack,
    output logic             out_valid,
    output logic [REC_W-1:0] out_rec,
    output logic [7:0]       out_seq,
    output logic             out_excp_valid,
    output logic             out_excp_mret,
    output logic [31:0]      out_excp_cause,
    output logic [63:0]      out_excp_pc,
    output logic [63:0]      commit_cnt,
    output logic [31:0]      stall_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] OCC_MAX = (AW+1)'(DEPTH - 2);

    typedef enum logic [1:0] {RUN, DRAIN, EXCP} state_e;

    logic [REC_W-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]      n_push, occ_d;
    logic [AW-1:0]    wr_idx0, wr_idx1;
    state_e           state_q, state_d;
    logic             push, pop, empty, ready_d;

    logic             in_ready_q, out_valid_q, out_excp_valid_q, excp_ack_q;
    logic [REC_W-1:0] out_rec_q;
    logic [7:0]       out_seq_q;
    logic [63:0]      commit_cnt_q;
    logic             lat_mret_q, out_excp_mret_q;
    logic [31:0]      lat_cause_q, out_excp_cause_q;
    logic [63:0]      lat_pc_q, out_excp_pc_q;

    // Same wrap bit plus same index means empty
    assign empty   = (wr_ptr_q[AW] == rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign push    = in_ready_q && in_valid[0];
    assign pop     = !empty;
    assign wr_idx0 = wr_ptr_q[AW-1:0];
    assign wr_idx1 = wr_ptr_q[AW-1:0] + AW'(1);

    always_comb begin
        n_push = '0;
        if (push) begin
            n_push = in_valid[1] ? (AW+1)'(2) : (AW+1)'(1);
        end
        wr_ptr_d = wr_ptr_q + n_push;
        rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, pop};
        occ_d    = wr_ptr_d - rd_ptr_d;
    end

    // An event waits in DRAIN until the last older commit has left the out_* registers
    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:     if (excp_req) state_d = DRAIN;
            DRAIN:   if (empty && !out_valid_q) state_d = EXCP;
            EXCP:    state_d = RUN;
            default: state_d = RUN;
        endcase
        ready_d = (state_d == RUN) && (occ_d <= OCC_MAX);
    end

    always_ff @(posedge clock) begin
        if (push) begin
            mem_q[wr_idx0] <= in_rec0;
            if (in_valid[1]) begin
                mem_q[wr_idx1] <= in_rec1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q          <= RUN;
            wr_ptr_q         <= '0;
            rd_ptr_q         <= '0;
            in_ready_q       <= 1'b0;
            out_valid_q      <= 1'b0;
            out_rec_q        <= '0;
            out_seq_q        <= '0;
            commit_cnt_q     <= '0;
            lat_mret_q       <= 1'b0;
            lat_cause_q      <= '0;
            lat_pc_q         <= '0;
            out_excp_valid_q <= 1'b0;
            excp_ack_q       <= 1'b0;
            out_excp_mret_q  <= 1'b0;
            out_excp_cause_q <= '0;
            out_excp_pc_q    <= '0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            in_ready_q  <= ready_d;
            out_valid_q <= pop;
            if (pop) begin
                out_rec_q    <= mem_q[rd_ptr_q[AW-1:0]];
                out_seq_q    <= out_seq_q + 8'd1;
                commit_cnt_q <= commit_cnt_q + 64'd1;
            end
            if (state_q == RUN && excp_req) begin
                lat_mret_q  <= excp_is_mret;
                lat_cause_q <= excp_cause;
                lat_pc_q    <= excp_pc;
            end
            out_excp_valid_q <= (state_d == EXCP);
            excp_ack_q       <= (state_d == EXCP);
            if (state_q == DRAIN && state_d == EXCP) begin
                out_excp_mret_q  <= lat_mret_q;
                out_excp_cause_q <= lat_cause_q;
                out_excp_pc_q    <= lat_pc_q;
            end
        end
    end

`ifdef DIFF_SCHED_STALL_CNT_EN
    logic [31:0] stall_cnt_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            stall_cnt_q <= '0;
        end else if (in_valid[0] && !in_ready_q && stall_cnt_q != 32'hFFFF_FFFF) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign stall_cnt = stall_cnt_q;
`else
    assign stall_cnt = '0;
`endif

    assign in_ready       = in_ready_q;
    assign excp_ack       = excp_ack_q;
    assign out_valid      = out_valid_q;
    assign out_rec        = out_rec_q;
    assign out_seq        = out_seq_q;
    assign out_excp_valid = out_excp_valid_q;
    assign out_excp_mret  = out_excp_mret_q;
    assign out_excp_cause = out_excp_cause_q;
    assign out_excp_pc    = out_excp_pc_q;
    assign commit_cnt     = commit_cnt_q;

endmodule

// File: tb/tb_diff_commit_sched.sv
// Self-checking bench for diff_commit_sched: directed steps with a commit scoreboard.
module tb_diff_commit_sched;

    localparam int DEPTH = 8;
    localparam int REC_W = 170;
    typedef logic [REC_W-1:0] rec_t;

    logic             clock = 1'b0;
    logic             reset_n = 1'b1;
    logic [1:0]       in_valid = '0;
    rec_t             in_rec0 = '0;
    rec_t             in_rec1 = '0;
    logic             in_ready;
    logic             excp_req = 1'b0;
    logic             excp_is_mret = 1'b0;
    logic [31:0]      excp_cause = '0;
    logic [63:0]      excp_pc = '0;
    logic             excp_ack;
    logic             out_valid;
    rec_t             out_rec;
    logic [7:0]       out_seq;
    logic             out_excp_valid;
    logic             out_excp_mret;
    logic [31:0]      out_excp_cause;
    logic [63:0]      out_excp_pc;
    logic [63:0]      commit_cnt;
    logic [31:0]      stall_cnt;

    always #5 clock = ~clock;

    diff_commit_sched #(.DEPTH(DEPTH), .REC_W(REC_W)) dut (
        .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_rec0(in_rec0),
        .in_rec1(in_rec1), .in_ready(in_ready), .excp_req(excp_req),
        .excp_is_mret(excp_is_mret), .excp_cause(excp_cause), .excp_pc(excp_pc),
        .excp_ack(excp_ack), .out_valid(out_valid), .out_rec(out_rec), .out_seq(out_seq),
        .out_excp_valid(out_excp_valid), .out_excp_mret(out_excp_mret),
        .out_excp_cause(out_excp_cause), .out_excp_pc(out_excp_pc),
        .commit_cnt(commit_cnt), .stall_cnt(stall_cnt)
    );

    int          tests = 0;
    int          fails = 0;
    rec_t        exp_q[$];
    logic [7:0]  m_seq = '0;
    logic [63:0] m_cnt = '0;
    logic [31:0] m_stall = '0;
    bit          excp_active = 0;
    bit          excp_seen = 0;
    logic        m_mret = 1'b0;
    logic [31:0] m_cause = '0;
    logic [63:0] m_pc = '0;
    int          ov_cnt = 0;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic rec_t mk_rec(input logic [63:0] pc, input logic [31:0] n);
        return {pc, 32'h0000_0013 ^ n, 1'b0, 1'b1, n[7:0], {32'hD00D_0000, n}};
    endfunction

    function automatic logic [31:0] exp_stall();
`ifdef DIFF_SCHED_STALL_CNT_EN
        return m_stall;
`else
        return 32'd0;
`endif
    endfunction

    // One clock: record accepted stimulus, advance, then check every output against the model
    task automatic tick();
        rec_t r;
        if (in_ready && in_valid[0]) begin
            exp_q.push_back(in_rec0);
            if (in_valid[1]) exp_q.push_back(in_rec1);
        end
        if (in_valid[0] && !in_ready && m_stall != 32'hFFFF_FFFF) m_stall++;
        @(posedge clock);
        #1;
        if (out_valid) begin
            ov_cnt++;
            check("out_valid_unexpected", exp_q.size() == 0, 0);
            if (exp_q.size() > 0) begin
                r = exp_q.pop_front();
                m_seq++;
                m_cnt++;
                check("out_rec", out_rec, r);
                check("out_seq", out_seq, m_seq);
                check("commit_cnt", commit_cnt, m_cnt);
            end
        end
        check("valid_exclusive", out_valid & out_excp_valid, 0);
        check("stall_cnt", stall_cnt, exp_stall());
        if (excp_active) check("in_ready_blocked", in_ready, 0);
        else check("in_ready", in_ready, exp_q.size() <= DEPTH - 2);
        if (out_excp_valid) begin
            excp_seen = 1;
            check("excp_expected", excp_active, 1);
            check("excp_after_commits", exp_q.size(), 0);
            check("excp_ack", excp_ack, 1);
            check("excp_mret", out_excp_mret, m_mret);
            check("excp_cause", out_excp_cause, m_cause);
            check("excp_pc", out_excp_pc, m_pc);
            excp_active = 0;
            excp_req = 1'b0;
        end else begin
            check("ack_without_event", excp_ack, 0);
        end
    endtask

    task automatic raise_excp(input logic mret, input logic [31:0] cause, input logic [63:0] pc);
        excp_req = 1'b1;
        excp_is_mret = mret;
        excp_cause = cause;
        excp_pc = pc;
        m_mret = mret;
        m_cause = cause;
        m_pc = pc;
        excp_active = 1;
    endtask

    task automatic wait_excp(input int max_cycles);
        excp_seen = 0;
        for (int i = 0; i < max_cycles && !excp_seen; i++) tick();
        check("excp_timeout", excp_seen, 1);
    endtask

    task automatic drain(input int max_cycles);
        in_valid = 2'b00;
        for (int i = 0; i < max_cycles && exp_q.size() > 0; i++) tick();
        check("drain_timeout", exp_q.size(), 0);
        tick();
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        in_valid = 2'b00;
        excp_req = 1'b0;
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_rec", out_rec, 0);
        check("rst_out_seq", out_seq, 0);
        check("rst_commit_cnt", commit_cnt, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_excp_valid", out_excp_valid, 0);
        check("rst_excp_ack", excp_ack, 0);
        check("rst_excp_cause", out_excp_cause, 0);
        check("rst_stall_cnt", stall_cnt, 0);
        exp_q.delete();
        m_seq = '0;
        m_cnt = '0;
        m_stall = '0;
        excp_active = 0;
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        tick();
    endtask

    initial begin
        int   k;
        int   pushed;
        bit   acc;
        bit   saw_stall;

        #2;
        do_reset();

        // Two-lane commit, order and latency
        in_rec0 = mk_rec(64'h8000_0000, 32'd1);
        in_rec1 = mk_rec(64'h8000_0004, 32'd2);
        in_valid = 2'b11;
        tick();
        in_valid = 2'b00;
        check("t1_no_bypass", out_valid, 0);
        tick();
        check("t1_first_valid", out_valid, 1);
        check("t1_first_pc", out_rec[169:106], 64'h8000_0000);
        check("t1_first_seq", out_seq, 1);
        tick();
        check("t1_second_pc", out_rec[169:106], 64'h8000_0004);
        check("t1_commit_cnt", commit_cnt, 2);
        tick();

        // Sustained two-wide push against one-wide drain
        k = 100;
        saw_stall = 0;
        in_rec0 = mk_rec(64'h9000_0000, k);
        in_rec1 = mk_rec(64'h9000_0004, k + 1);
        for (int i = 0; i < 20; i++) begin
            in_valid = 2'b11;
            acc = in_ready;
            if (!in_ready) saw_stall = 1;
            tick();
            if (acc) begin
                k += 2;
                in_rec0 = mk_rec(64'h9000_0000 + 64'(k) * 4, k);
                in_rec1 = mk_rec(64'h9000_0004 + 64'(k) * 4, k + 1);
            end
        end
        drain(20);
        check("t2_stall_seen", saw_stall, 1);

        // Three commits then exception, drained first
        ov_cnt = 0;
        in_rec0 = mk_rec(64'hA000_0000, 32'd200);
        in_rec1 = mk_rec(64'hA000_0004, 32'd201);
        in_valid = 2'b11;
        tick();
        in_rec0 = mk_rec(64'hA000_0008, 32'd202);
        in_valid = 2'b01;
        tick();
        in_valid = 2'b00;
        raise_excp(1'b0, 32'd2, 64'h8000_0010);
        wait_excp(20);
        check("t3_commits_before_excp", ov_cnt, 3);
        tick();

        // Commit accepted in the same cycle as the event is older than it
        ov_cnt = 0;
        in_rec0 = mk_rec(64'hB000_0000, 32'd300);
        in_valid = 2'b01;
        raise_excp(1'b1, 32'd3, 64'hB000_0040);
        tick();
        in_valid = 2'b00;
        wait_excp(20);
        check("t4_commit_first", ov_cnt, 1);
        tick();

        // Sequence number wrap over 300 commits
        do_reset();
        pushed = 0;
        for (int i = 0; i < 400 && pushed < 300; i++) begin
            in_rec0 = mk_rec(64'hC000_0000 + 64'(pushed) * 4, pushed);
            in_rec1 = mk_rec(64'hC000_0004 + 64'(pushed) * 4, pushed + 1);
            in_valid = 2'b11;
            acc = in_ready;
            tick();
            if (acc) pushed += 2;
        end
        check("t5_pushed", pushed, 300);
        drain(20);
        check("t5_last_seq", out_seq, 8'd44);
        check("t5_commit_cnt", commit_cnt, 64'd300);

        // Reset in the middle of a drain
        for (int i = 0; i < 3; i++) begin
            in_rec0 = mk_rec(64'hD000_0000, 32'd400 + i * 2);
            in_rec1 = mk_rec(64'hD000_0004, 32'd401 + i * 2);
            in_valid = 2'b11;
            if (i == 2) raise_excp(1'b0, 32'd7, 64'hD000_0100);
            tick();
        end
        in_valid = 2'b00;
        do_reset();
        ov_cnt = 0;
        excp_seen = 0;
        for (int i = 0; i < 10; i++) tick();
        check("t6_no_stale_commit", ov_cnt, 0);
        check("t6_no_stale_excp", excp_seen, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
